// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and fills the IF/ID register.
// Optional performance counters are enabled with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] END_ADDR = 32'd128,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic        halted_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] alignedTarget;
    logic [31:0] seqPc;

    assign alignedTarget = branch_target_i & 32'hFFFF_FFFC;
    assign seqPc         = pc_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pcPlus4_q <= 32'd0;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcPlus4_q <= pcPlus4_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    // Halt is decided on the PC value being loaded, so a redirect past program space halts too.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcPlus4_d = pcPlus4_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        if (flush_i) begin
            pc_d      = alignedTarget;
            pcPlus4_d = 32'd0;
            instr_d   = 32'd0;
            valid_d   = 1'b0;
            state_d   = (alignedTarget >= END_ADDR) ? HALT : RUN;
        end else if (!stall_i) begin
            if (state_q == RUN) begin
                pc_d      = seqPc;
                pcPlus4_d = seqPc;
                instr_d   = imem_instr_i;
                valid_d   = 1'b1;
                if (seqPc >= END_ADDR) begin
                    state_d = HALT;
                end
            end else begin
                instr_d = 32'd0;
                valid_d = 1'b0;
            end
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_plus4_o  = pcPlus4_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;
    assign halted_o    = (state_q == HALT);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetchCnt_q, fetchCnt_d;
    logic [31:0] stallCnt_q, stallCnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetchCnt_q <= 32'd0;
            stallCnt_q <= 32'd0;
        end else begin
            fetchCnt_q <= fetchCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Both counters saturate rather than wrap and only advance while running.
    always_comb begin
        fetchCnt_d = fetchCnt_q;
        stallCnt_d = stallCnt_q;
        if (state_q == RUN && !flush_i) begin
            if (!stall_i && fetchCnt_q != 32'hFFFF_FFFF) begin
                fetchCnt_d = fetchCnt_q + 32'd1;
            end
            if (stall_i && stallCnt_q != 32'hFFFF_FFFF) begin
                stallCnt_d = stallCnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetchCnt_q;
    assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed test-plan steps followed by random
// stall/flush/reset traffic, all compared against a behavioural fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] END_ADDR = 32'd128;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        halted_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    logic [31:0] mem [0:63];

    // Behavioural model state
    logic [31:0] mPc;
    logic [31:0] mPcPlus4;
    logic [31:0] mInstr;
    logic        mValid;
    logic        mHalted;
    logic [31:0] mFetchCnt;
    logic [31:0] mStallCnt;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .END_ADDR(END_ADDR),
        .RESET_PC(32'd0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_target_i(branch_target_i),
        .imem_addr_o    (imem_addr_o),
        .imem_instr_i   (imem_instr_i),
        .pc_plus4_o     (pc_plus4_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o),
`ifdef IFU_PERF_CNT_EN
        .fetch_cnt_o    (fetch_cnt_o),
        .stall_cnt_o    (stall_cnt_o),
`endif
        .halted_o       (halted_o)
    );

    assign imem_instr_i = mem[imem_addr_o[7:2]];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "/pc"}, imem_addr_o, mPc);
        checkVal({tag, "/pc_plus4"}, pc_plus4_o, mPcPlus4);
        checkVal({tag, "/instr"}, instr_o, mInstr);
        checkVal({tag, "/valid"}, {31'd0, valid_o}, {31'd0, mValid});
        checkVal({tag, "/halted"}, {31'd0, halted_o}, {31'd0, mHalted});
`ifdef IFU_PERF_CNT_EN
        checkVal({tag, "/fetch_cnt"}, fetch_cnt_o, mFetchCnt);
        checkVal({tag, "/stall_cnt"}, stall_cnt_o, mStallCnt);
`endif
    endtask

    // One clock edge with the given controls; the model follows the fetch-stage rules directly.
    task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] target,
                                 input string tag);
        logic [31:0] dest;
        stall_i         = stall;
        flush_i         = flush;
        branch_target_i = target;
        @(posedge clk_i);
        dest = (target / 4) * 4;
        if (flush) begin
            mPc      = dest;
            mInstr   = 32'd0;
            mValid   = 1'b0;
            mPcPlus4 = 32'd0;
            mHalted  = (dest >= END_ADDR);
        end else if (stall) begin
            if (!mHalted) mStallCnt = mStallCnt + 1;
        end else if (mHalted) begin
            mInstr = 32'd0;
            mValid = 1'b0;
        end else begin
            mInstr    = mem[(mPc / 4) % 64];
            mPcPlus4  = mPc + 4;
            mValid    = 1'b1;
            mPc       = mPc + 4;
            mHalted   = (mPc >= END_ADDR);
            mFetchCnt = mFetchCnt + 1;
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset(input logic stall, input string tag);
        rst_i   = 1'b0;
        stall_i = stall;
        flush_i = 1'b0;
        @(posedge clk_i);
        mPc       = 32'd0;
        mPcPlus4  = 32'd0;
        mInstr    = 32'd0;
        mValid    = 1'b0;
        mHalted   = 1'b0;
        mFetchCnt = 32'd0;
        mStallCnt = 32'd0;
        #1;
        checkOutput(tag);
        rst_i = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'h2008_0001 + i;
        rst_i           = 1'b1;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        branch_target_i = 32'd0;
        #2;

        applyReset(1'b0, "reset");
        checkVal("reset/instr_zero", instr_o, 32'd0);

        applyStimulus(1'b0, 1'b0, 32'd0, "fetch0");
        checkVal("fetch0/plan", instr_o, 32'h2008_0001);
        applyStimulus(1'b0, 1'b0, 32'd0, "fetch1");
        checkVal("fetch1/plan_pc4", pc_plus4_o, 32'd8);

        applyStimulus(1'b1, 1'b0, 32'd0, "stall0");
        applyStimulus(1'b1, 1'b0, 32'd0, "stall1");
        checkVal("stall1/hold_instr", instr_o, 32'h2008_0002);
        applyStimulus(1'b0, 1'b0, 32'd0, "resume");
        checkVal("resume/instr", instr_o, 32'h2008_0003);
        checkVal("resume/pc4", pc_plus4_o, 32'd12);

        applyStimulus(1'b0, 1'b1, 32'h22, "flush22");
        checkVal("flush22/pc", imem_addr_o, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'd0, "after_flush");
        checkVal("after_flush/instr", instr_o, mem[8]);
        checkVal("after_flush/pc4", pc_plus4_o, 32'h24);

        applyStimulus(1'b1, 1'b1, 32'h40, "flush_stall");
        checkVal("flush_stall/pc", imem_addr_o, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'd0, "post40");

        for (int i = 0; i < 40 && !mHalted; i++) applyStimulus(1'b0, 1'b0, 32'd0, "run_to_end");
        checkVal("halt/pc", imem_addr_o, 32'd128);
        checkVal("halt/flag", {31'd0, halted_o}, 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, "halt_bubble");
        applyStimulus(1'b1, 1'b0, 32'd0, "halt_stall");
        applyStimulus(1'b0, 1'b1, 32'h10, "halt_resume");
        checkVal("halt_resume/flag", {31'd0, halted_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, "resume_fetch");
        applyStimulus(1'b0, 1'b1, 32'h84, "flush_past_end");
        applyStimulus(1'b0, 1'b0, 32'd0, "flush_past_end_bubble");

        applyReset(1'b1, "reset_in_halt");
        checkVal("reset_in_halt/pc", imem_addr_o, 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                applyReset($urandom_range(0, 1) == 1, "rand_reset");
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                              32'($urandom_range(0, 160)), "random");
            end
        end

        for (int i = 0; i < 40 && !mHalted; i++) applyStimulus(1'b0, 1'b0, 32'd0, "final_run");
        applyReset(1'b0, "final_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
